// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Memory stage for loads/stores over an Avalon-style bus with
//            waitrequest, load extraction/merge and store lane steering.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  loadcontrol,
    input  logic [1:0]  storecontrol,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rt_old,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        addr_err,
    output logic        bus_err
);

    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LBU = 3'b001;
    localparam logic [2:0] c_LH  = 3'b010;
    localparam logic [2:0] c_LHU = 3'b011;
    localparam logic [2:0] c_LUI = 3'b100;
    localparam logic [2:0] c_LW  = 3'b101;
    localparam logic [2:0] c_LWL = 3'b110;
    localparam logic [2:0] c_LWR = 3'b111;
    localparam logic [1:0] c_SB  = 2'b00;
    localparam logic [1:0] c_SH  = 2'b01;
    localparam logic [1:0] c_SW  = 2'b10;
    localparam logic [1:0] c_SX  = 2'b11;
    localparam int         c_CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [2:0]        r_lctl;
    logic [1:0]        r_k;
    logic [31:0]       r_rt;
    logic [c_CW-1:0]   r_wcnt;
    logic [31:0]       r_address;
    logic              r_read;
    logic              r_write;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_done;
    logic              r_aerr;
    logic              r_berr;

    state_t            w_state_nxt;
    logic              w_capture;
    logic [c_CW-1:0]   w_wcnt_nxt;
    logic              w_read_nxt;
    logic              w_write_nxt;
    logic [31:0]       w_rdata_nxt;
    logic              w_done_nxt;
    logic              w_aerr_nxt;
    logic              w_berr_nxt;
    logic [1:0]        w_k;
    logic              w_misalign;
    logic              w_lui;
    logic [3:0]        w_st_be;
    logic [31:0]       w_st_data;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [4:0]        w_lsh;
    logic [4:0]        w_rsh;
    logic [31:0]       w_load;

    // Request decode: alignment check and store lane steering.
    always_comb begin
        w_k        = addr[1:0];
        w_lui      = !is_store && (loadcontrol == c_LUI);
        w_misalign = 1'b0;
        w_st_be    = 4'b1111;
        w_st_data  = wdata;
        if (is_store) begin
            w_misalign = (storecontrol == c_SX) ||
                         ((storecontrol == c_SH) && w_k[0]) ||
                         ((storecontrol == c_SW) && (w_k != 2'b00));
        end else begin
            w_misalign = (((loadcontrol == c_LH) || (loadcontrol == c_LHU)) && w_k[0]) ||
                         ((loadcontrol == c_LW) && (w_k != 2'b00));
        end
        case (storecontrol)
            c_SB: begin
                w_st_be   = 4'b0001 << w_k;
                w_st_data = {4{wdata[7:0]}};
            end
            c_SH: begin
                w_st_be   = 4'b0011 << w_k;
                w_st_data = {2{wdata[15:0]}};
            end
            default: begin
                w_st_be   = 4'b1111;
                w_st_data = wdata;
            end
        endcase
    end

    // Load extraction; 8*(3-k) equals {~k,3'b000} for a 2-bit k.
    always_comb begin
        w_byte = avm_readdata[{r_k, 3'b000} +: 8];
        w_half = r_k[1] ? avm_readdata[31:16] : avm_readdata[15:0];
        w_lsh  = {~r_k, 3'b000};
        w_rsh  = {r_k, 3'b000};
        w_load = 32'h0;
        case (r_lctl)
            c_LB:    w_load = {{24{w_byte[7]}}, w_byte};
            c_LBU:   w_load = {24'h0, w_byte};
            c_LH:    w_load = {{16{w_half[15]}}, w_half};
            c_LHU:   w_load = {16'h0, w_half};
            c_LW:    w_load = avm_readdata;
            c_LWL:   w_load = (avm_readdata << w_lsh) | (r_rt & ~(32'hFFFF_FFFF << w_lsh));
            c_LWR:   w_load = (avm_readdata >> w_rsh) | (r_rt & ~(32'hFFFF_FFFF >> w_rsh));
            default: w_load = 32'h0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_wcnt_nxt  = r_wcnt;
        w_read_nxt  = r_read;
        w_write_nxt = r_write;
        w_rdata_nxt = r_rdata;
        w_done_nxt  = 1'b0;
        w_aerr_nxt  = 1'b0;
        w_berr_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_capture  = 1'b1;
                    w_wcnt_nxt = '0;
                    if (w_misalign) begin
                        w_state_nxt = S_RESP;
                        w_done_nxt  = 1'b1;
                        w_aerr_nxt  = 1'b1;
                        w_rdata_nxt = 32'h0;
                    end else if (w_lui) begin
                        w_state_nxt = S_RESP;
                        w_done_nxt  = 1'b1;
                        w_rdata_nxt = {addr[15:0], 16'h0};
                    end else if (is_store) begin
                        w_state_nxt = S_WRITE;
                        w_write_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_READ;
                        w_read_nxt  = 1'b1;
                    end
                end
            end
            S_READ, S_WRITE: begin
                // The strobe's first cycle sees count 0, so the abort lands after TIMEOUT further stalled cycles.
                if (!avm_waitrequest) begin
                    w_state_nxt = S_RESP;
                    w_read_nxt  = 1'b0;
                    w_write_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_rdata_nxt = (r_state == S_READ) ? w_load : 32'h0;
                end else if (r_wcnt == c_CW'(TIMEOUT)) begin
                    w_state_nxt = S_RESP;
                    w_read_nxt  = 1'b0;
                    w_write_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_berr_nxt  = 1'b1;
                    w_rdata_nxt = 32'h0;
                end else begin
                    w_wcnt_nxt = r_wcnt + c_CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_lctl    <= 3'b000;
            r_k       <= 2'b00;
            r_rt      <= 32'h0;
            r_wcnt    <= '0;
            r_address <= 32'h0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_be      <= 4'b0000;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_done    <= 1'b0;
            r_aerr    <= 1'b0;
            r_berr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_read  <= w_read_nxt;
            r_write <= w_write_nxt;
            r_rdata <= w_rdata_nxt;
            r_done  <= w_done_nxt;
            r_aerr  <= w_aerr_nxt;
            r_berr  <= w_berr_nxt;
            if (w_capture) begin
                r_lctl    <= loadcontrol;
                r_k       <= w_k;
                r_rt      <= rt_old;
                r_address <= {addr[31:2], 2'b00};
                r_be      <= is_store ? w_st_be : 4'b1111;
                r_wdata   <= is_store ? w_st_data : 32'h0;
            end
        end
    end

    assign req_ready      = (r_state == S_IDLE);
    assign stall          = ((r_state == S_IDLE) && req_valid) ||
                            (r_state == S_READ) || (r_state == S_WRITE);
    assign avm_address    = r_address;
    assign avm_read       = r_read;
    assign avm_write      = r_write;
    assign avm_byteenable = r_be;
    assign avm_writedata  = r_wdata;
    assign rdata          = r_rdata;
    assign done           = r_done;
    assign addr_err       = r_aerr;
    assign bus_err        = r_berr;

endmodule
`default_nettype wire
